// File: rtl/nor_selftest_seq.sv
// nor_selftest_seq: clocked stimulus/check controller for a single NOR gate.
// Walks (a,b) through 00,10,01,11, holds each vector HOLD_CYCLES cycles,
// compares w against ~(a|b) and reports per-vector errors plus pass/fail.
module nor_selftest_seq #(
  parameter int unsigned HOLD_CYCLES = 30,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       w,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]       LAST_VEC    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       vec_idx;
  logic [CNT_W-1:0] hold_cnt;

  logic       exp_w_c;
  logic       mismatch_c;
  logic [1:0] vec_nxt_c;
  logic [2:0] err_nxt_c;
  logic [3:0] fail_nxt_c;

  // Expected NOR output: only vector 0 (a=0,b=0) yields 1.
  assign exp_w_c    = (vec_idx == 2'd0);
  assign mismatch_c = (w != exp_w_c);
  assign vec_nxt_c  = vec_idx + 2'd1;
  assign err_nxt_c  = err_count + 3'(mismatch_c);
  assign fail_nxt_c = fail_vec | (4'(mismatch_c) << vec_idx);

  // Sequencer state, vector drive and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      vec_idx   <= 2'd0;
      hold_cnt  <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          a    <= 1'b0;
          b    <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state     <= S_APPLY;
            vec_idx   <= 2'd0;
            hold_cnt  <= HOLD_RELOAD;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
            busy      <= 1'b1;
          end
        end

        S_APPLY: begin
          if (hold_cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end
        end

        S_SAMPLE: begin
          err_count <= err_nxt_c;
          fail_vec  <= fail_nxt_c;
          if (vec_idx == LAST_VEC) begin
            state <= S_DONE;
            done  <= 1'b1;
            a     <= 1'b0;
            b     <= 1'b0;
            pass  <= (err_nxt_c == 3'd0);
          end else begin
            state    <= S_APPLY;
            vec_idx  <= vec_nxt_c;
            hold_cnt <= HOLD_RELOAD;
            a        <= vec_nxt_c[0];
            b        <= vec_nxt_c[1];
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nor_selftest_seq.sv
// Scoreboard bench for nor_selftest_seq with a switchable gate model on w.
module tb_nor_selftest_seq;

  localparam int unsigned H   = 4;
  localparam int          RUN = 4 * (H + 1);

  logic       clk;
  logic       rst;
  logic       start;
  logic       w;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  int mode;        // 0 NOR, 1 stuck-0, 2 stuck-1, 3 OR
  int cyc;
  int n_checks;
  int n_fail;
  int done_seen;

  typedef struct {
    int         cyc;
    logic [2:0] err;
    logic [3:0] fv;
    logic       pass;
  } exp_t;

  exp_t       q[$];
  logic [1:0] tr[64];
  int         tr_len;

  nor_selftest_seq #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .w(w), .a(a), .b(b),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Gate under control.
  always_comb begin
    case (mode)
      1:       w = 1'b0;
      2:       w = 1'b1;
      3:       w = a | b;
      default: w = ~(a | b);
    endcase
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: records the driven vectors and scores each done pulse.
  always @(negedge clk) begin
    if (rst) begin
      tr_len = 0;
    end else if (done) begin
      int   bad;
      exp_t e;
      bad = (tr_len != RUN) ? 1 : 0;
      for (int k = 0; k < RUN && k < tr_len; k++)
        if (tr[k] != 2'(k / (H + 1))) bad++;
      check("ab_seq", bad, 0);
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("done_cyc", cyc, e.cyc);
        check("err_count", int'(err_count), int'(e.err));
        check("fail_vec", int'(fail_vec), int'(e.fv));
        check("pass", int'(pass), int'(e.pass));
      end
      done_seen++;
      tr_len = 0;
    end else if (busy) begin
      if (tr_len < 64) tr[tr_len] = {b, a};
      tr_len++;
    end
  end

  // Launch one run with gate model m and queue its expected result.
  task automatic run(input int m, input logic [2:0] e, input logic [3:0] f, input logic p);
    exp_t x;
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = '{cyc + RUN, e, f, p};
    q.push_back(x);
    repeat (RUN + 3) @(negedge clk);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_a"}, int'(a), 0);
    check({tag, "_b"}, int'(b), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_count), 0);
    check({tag, "_fail"}, int'(fail_vec), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    exp_t x;
    int   t0;
    cyc       = 0;
    n_checks  = 0;
    n_fail    = 0;
    done_seen = 0;
    tr_len    = 0;
    mode      = 0;
    rst       = 1'b1;
    start     = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    run(0, 3'd0, 4'b0000, 1'b1);
    run(1, 3'd1, 4'b0001, 1'b0);
    run(2, 3'd3, 4'b1110, 1'b0);
    run(3, 3'd4, 4'b1111, 1'b0);
    run(0, 3'd0, 4'b0000, 1'b1);

    // start raised in APPLY of vector 2 and held through DONE.
    mode  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    x = '{t0 + RUN, 3'd0, 4'b0000, 1'b1};
    q.push_back(x);
    x = '{t0 + RUN + 2 + RUN, 3'd0, 4'b0000, 1'b1};
    q.push_back(x);
    while (cyc < t0 + 2 * (H + 1) + 1) @(negedge clk);
    start = 1'b1;
    while (cyc < t0 + RUN + 2) @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 2 * RUN + 5) @(negedge clk);

    // Reset during APPLY of vector 1.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    while (cyc < t0 + H + 2) @(negedge clk);
    check("mid_a", int'(a), 1);
    check("mid_b", int'(b), 0);
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_reset("abort");
    rst = 1'b0;
    repeat (RUN + 3) @(negedge clk);
    run(0, 3'd0, 4'b0000, 1'b1);

    check("queue_empty", q.size(), 0);
    check("done_count", done_seen, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nor_selftest_seq.md
Name: nor_selftest_seq

Overview:
- Sequencer that drives the two inputs of a single NOR-gate datapath through its full truth table.
- Samples the gate output against the expected NOR value after each vector and reports pass/fail with per-vector error flags.
- Sits beside the NOR gate instance as its on-chip stimulus/check controller, replacing hand-timed stimulus with a clocked, repeatable run.

Parameters:
- HOLD_CYCLES, 30, clock cycles each vector is held before sampling; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  run request, sampled only in IDLE
- w  input  1  output of the NOR gate under control
- a  output  1  NOR gate input a
- b  output  1  NOR gate input b
- busy  output  1  high from the first APPLY cycle through the DONE cycle
- done  output  1  one-cycle pulse at end of run
- pass  output  1  1 when the last completed run had zero errors
- err_count  output  3  number of mismatching vectors in the last run, 0..4
- fail_vec  output  4  bit i set when vector i mismatched

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a clock edge):
  - state=IDLE, vector index=0, hold counter=0.
  - a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
  - Reset overrides every other input, including mid-run; the run is abandoned with no done pulse.
- Vector order by index i=0..3: a=i[0], b=i[1], giving (a,b)=00,10,01,11. Expected w = ~(a|b) = 1,0,0,0.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - a=b=0, busy=0.
  - On start=1: go to APPLY, i=0, counter=HOLD_CYCLES-1, and clear err_count and fail_vec.
  - pass keeps its previous value until the next DONE.
- APPLY:
  - Drive vector i on a,b (registered outputs) and decrement the counter each cycle.
  - When counter==0, go to SAMPLE. APPLY lasts exactly HOLD_CYCLES cycles.
- SAMPLE:
  - Vector i is still driven. Compare w with expected at this edge.
  - On mismatch: set fail_vec[i] and increment err_count.
  - If i==3, go to DONE. Otherwise i=i+1, reload counter=HOLD_CYCLES-1, go to APPLY.
- DONE:
  - done=1 for this single cycle, busy=1, a=b=0.
  - pass is registered from the final error state (including the vector-3 compare) and becomes valid in the same cycle as done.
  - Next state is IDLE.
- Timing:
  - Each vector occupies HOLD_CYCLES+1 cycles.
  - If start is sampled at edge T, APPLY begins at T+1 and done is high in cycle T+1+4*(HOLD_CYCLES+1). With the default, that is T+125.
- start is ignored in APPLY, SAMPLE and DONE. If start is held high continuously, the next run begins the cycle after returning to IDLE.
- err_count, fail_vec and pass hold their values after DONE until the next accepted start or reset.
- HOLD_CYCLES=1: APPLY lasts 1 cycle, so each vector takes 2 cycles.
- w is assumed combinationally driven from a,b within one cycle. No synchronizer is included.

Test Plan:
- Correct NOR model, HOLD_CYCLES=4, start pulse at edge T -> (a,b) sequence 00,10,01,11, each held 5 cycles; done pulse at T+21; pass=1, err_count=0, fail_vec=0000.
- w stuck at 0 -> err_count=1, fail_vec=0001, pass=0.
- w stuck at 1 -> err_count=3, fail_vec=1110, pass=0.
- OR gate substituted (w=a|b) -> err_count=4, fail_vec=1111, pass=0. Then a second run with the correct NOR -> err_count and fail_vec cleared at start, pass=1 at done.
- start pulsed during APPLY of vector 2, and held high through DONE -> first run is unaffected; second run's APPLY begins exactly 2 cycles after the first done pulse.
- rst asserted in APPLY of vector 1 -> next cycle: a=b=0, busy=0, err_count=0, fail_vec=0, pass=0, no done pulse. A fresh start then completes normally with pass=1.
